adc_sample_fifo: RTL and testbench

- Downstream consumer of the ADC SPI controller.
- Captures each 12-bit conversion result when the controller's one-cycle ready strobe fires, and buffers it in a circular FIFO.
- Drains the FIFO as a two-byte-per-sample stream over a valid/ack byte interface toward the host link (UART/USB bridge).
- Sized to hold a full continuous-mode burst (20 samples) with margin, and reports overflow.

---
 rtl/adc_pkg.sv | 15 +
 rtl/fifo_mem_sync.sv | 27 ++
 rtl/adc_sample_fifo.sv | 126 ++++++++++++
 tb/tb_adc_sample_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample FIFO: sample width, stream marker and
// serializer state encoding.
package adc_pkg;

    localparam int         SAMPLE_W   = 12;
    localparam logic [3:0] MARKER_DEF = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HI   = 2'd2,
        ST_LO   = 2'd3
    } ser_state_e;

endpackage

// File: rtl/fifo_mem_sync.sv
// Sample storage: one write port and one registered read port, no reset.
// Reading and writing the same address in one cycle returns the old contents.
module fifo_mem_sync
    import adc_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk_in,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [SAMPLE_W-1:0] wdata_i,
    input  logic                re_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [SAMPLE_W-1:0] rdata_o
);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we_i)
            mem_q[waddr_i] <= wdata_i;
        if (re_i)
            rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/adc_sample_fifo.sv
// Captures ADC conversion results on the ready strobe's rising edge, buffers
// them, and streams each as {MARKER, d[11:8]} then d[7:0] over valid/ack.
module adc_sample_fifo
    import adc_pkg::*;
#(
    parameter int         DEPTH  = 32,
    parameter int         ADDR_W = 5,
    parameter logic [3:0] MARKER = MARKER_DEF
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] data_in,
    input  logic                ready_in,
    input  logic                flush,
    output logic [7:0]          byte_out,
    output logic                byte_valid,
    input  logic                byte_ack,
    output logic [ADDR_W:0]     count,
    output logic                empty,
    output logic                full,
    output logic                overflow
);

    localparam int CNT_W = ADDR_W + 1;

    logic                ready_q;
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                empty_q, full_q, overflow_q;
    logic [7:0]          byte_out_q;
    logic                byte_valid_q;
    ser_state_e          state_q;
    logic [SAMPLE_W-1:0] shift_word;

    logic push, xfer, pop, push_ok, drop;

    assign push    = ready_in & ~ready_q & ~flush;
    assign xfer    = byte_valid_q & byte_ack;
    assign pop     = ~flush & ~empty_q &
                     ((state_q == ST_IDLE) | ((state_q == ST_LO) & xfer));
    // A pop in the same cycle frees the slot a push at full needs.
    assign push_ok = push & (~full_q | pop);
    assign drop    = push & full_q & ~pop;

    always_comb begin
        count_d = count_q;
        if (flush)
            count_d = '0;
        else if (push_ok & ~pop)
            count_d = count_q + CNT_W'(1);
        else if (pop & ~push_ok)
            count_d = count_q - CNT_W'(1);
    end

    fifo_mem_sync #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_in  (clk_in),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .re_i    (pop),
        .raddr_i (rd_ptr_q),
        .rdata_o (shift_word)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ready_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            ready_q <= ready_in;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CNT_W'(DEPTH));
            if (flush) begin
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                overflow_q   <= 1'b0;
                byte_valid_q <= 1'b0;
                state_q      <= ST_IDLE;
            end else begin
                if (push_ok)
                    wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                if (pop)
                    rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                if (drop)
                    overflow_q <= 1'b1;
                unique case (state_q)
                    ST_IDLE: if (!empty_q) state_q <= ST_LOAD;
                    ST_LOAD: begin
                        byte_out_q   <= {MARKER, shift_word[11:8]};
                        byte_valid_q <= 1'b1;
                        state_q      <= ST_HI;
                    end
                    ST_HI: if (xfer) begin
                        byte_out_q <= shift_word[7:0];
                        state_q    <= ST_LO;
                    end
                    ST_LO: if (xfer) begin
                        byte_valid_q <= 1'b0;
                        state_q      <= empty_q ? ST_IDLE : ST_LOAD;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign count      = count_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed bench for adc_sample_fifo: capture, streaming, back-pressure,
// overflow, push/pop at full, wide strobe, flush and asynchronous reset.
module tb_adc_sample_fifo;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [11:0] data_in;
    logic        ready_in;
    logic        flush;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ack;
    logic [5:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    adc_sample_fifo dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .ready_in   (ready_in),
        .flush      (flush),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ack   (byte_ack),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic [11:0] d);
        data_in  = d;
        ready_in = 1'b1;
        @(negedge clk_in);
        ready_in = 1'b0;
        @(negedge clk_in);
    endtask

    // Waits (bounded) for a valid byte, checks it together with valid,
    // then lets the next edge transfer it (byte_ack must already be high).
    task automatic get_byte(input string tag, input logic [7:0] exp);
        int k;
        k = 0;
        while (!byte_valid && k < 20) begin
            @(negedge clk_in);
            k++;
        end
        chk(tag, {7'd0, byte_valid, byte_out}, {8'h01, exp});
        @(negedge clk_in);
    endtask

    task automatic drain(input string tag, input int n, input logic [11:0] base);
        logic [11:0] s;
        for (int i = 0; i < n; i++) begin
            s = base + 12'(i);
            get_byte({tag, "_hi"}, {4'hA, s[11:8]});
            get_byte({tag, "_lo"}, s[7:0]);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        data_in  = '0;
        ready_in = 1'b0;
        flush    = 1'b0;
        byte_ack = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_count", 16'(count), 16'd0);
        chk("rst_flags", {13'd0, empty, full, overflow}, 16'b100);
        chk("rst_byte", {7'd0, byte_valid, byte_out}, 16'h000);
        rst_n = 1'b1;
        @(negedge clk_in);

        // Single sample, exact latency with ack held high
        byte_ack = 1'b1;
        data_in  = 12'h5A3;
        ready_in = 1'b1;
        @(negedge clk_in);
        ready_in = 1'b0;
        @(negedge clk_in);
        chk("single_notyet", {15'd0, byte_valid}, 16'd0);
        @(negedge clk_in);
        chk("single_hi", {7'd0, byte_valid, byte_out}, 16'h1A5);
        @(negedge clk_in);
        chk("single_lo", {7'd0, byte_valid, byte_out}, 16'h1A3);
        @(negedge clk_in);
        chk("single_done", {14'd0, byte_valid, empty}, 16'b01);

        // Back-pressure
        byte_ack = 1'b0;
        pulse(12'h001);
        pulse(12'h802);
        pulse(12'hFFF);
        repeat (10) @(negedge clk_in);
        chk("bp_hold", {7'd0, byte_valid, byte_out}, 16'h1A0);
        chk("bp_count", 16'(count), 16'd2);
        byte_ack = 1'b1;
        get_byte("bp0", 8'hA0);
        get_byte("bp1", 8'h01);
        get_byte("bp2", 8'hA8);
        get_byte("bp3", 8'h02);
        get_byte("bp4", 8'hAF);
        get_byte("bp5", 8'hFF);
        repeat (2) @(negedge clk_in);
        chk("bp_done", {14'd0, byte_valid, empty}, 16'b01);

        // Overflow: 1 in serializer + 32 stored, 34th dropped
        byte_ack = 1'b0;
        for (int i = 0; i < 33; i++) pulse(12'(i));
        chk("ovf_full", {13'd0, empty, full, overflow}, 16'b010);
        chk("ovf_count32", 16'(count), 16'd32);
        pulse(12'd33);
        chk("ovf_flag", {13'd0, empty, full, overflow}, 16'b011);
        chk("ovf_count_hold", 16'(count), 16'd32);
        byte_ack = 1'b1;
        drain("ovf", 33, 12'd0);
        repeat (2) @(negedge clk_in);
        chk("ovf_drained", {13'd0, empty, full, overflow}, 16'b101);
        chk("ovf_tail", {15'd0, byte_valid}, 16'd0);
        flush = 1'b1;
        @(negedge clk_in);
        flush = 1'b0;
        chk("flush_clears_ovf", {13'd0, empty, full, overflow}, 16'b100);

        // Simultaneous push and pop while full
        byte_ack = 1'b0;
        for (int i = 0; i < 33; i++) pulse(12'h100 + 12'(i));
        chk("pp_full", {13'd0, empty, full, overflow}, 16'b010);
        byte_ack = 1'b1;
        @(negedge clk_in);
        chk("pp_in_lo", {7'd0, byte_valid, byte_out}, 16'h100);
        data_in  = 12'h3AB;
        ready_in = 1'b1;
        @(negedge clk_in);
        ready_in = 1'b0;
        byte_ack = 1'b0;
        chk("pp_count", 16'(count), 16'd32);
        chk("pp_flags", {13'd0, empty, full, overflow}, 16'b010);
        byte_ack = 1'b1;
        drain("pp", 32, 12'h101);
        get_byte("pp_last_hi", 8'hA3);
        get_byte("pp_last_lo", 8'hAB);
        repeat (2) @(negedge clk_in);
        chk("pp_done", {14'd0, byte_valid, empty}, 16'b01);

        // Wide strobe stores one sample
        byte_ack = 1'b0;
        pulse(12'h123);
        data_in  = 12'h777;
        ready_in = 1'b1;
        repeat (5) @(negedge clk_in);
        ready_in = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("wide_count", 16'(count), 16'd1);
        chk("wide_hold", {7'd0, byte_valid, byte_out}, 16'h1A1);

        // Flush while in HI, with a push and an ack in the same cycle
        flush    = 1'b1;
        data_in  = 12'h555;
        ready_in = 1'b1;
        byte_ack = 1'b1;
        @(negedge clk_in);
        flush    = 1'b0;
        ready_in = 1'b0;
        byte_ack = 1'b0;
        chk("flush_valid", {15'd0, byte_valid}, 16'd0);
        chk("flush_count", 16'(count), 16'd0);
        chk("flush_flags", {13'd0, empty, full, overflow}, 16'b100);
        repeat (3) @(negedge clk_in);
        chk("flush_stays_idle", {7'd0, byte_valid, 2'd0, count}, 16'h000);

        // Asynchronous reset while in LO
        pulse(12'h456);
        byte_ack = 1'b1;
        get_byte("rst_mid_hi", 8'hA4);
        byte_ack = 1'b0;
        chk("rst_mid_lo", {7'd0, byte_valid, byte_out}, 16'h156);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_byte", {7'd0, byte_valid, byte_out}, 16'h000);
        chk("arst_flags", {13'd0, empty, full, overflow}, 16'b100);
        chk("arst_count", 16'(count), 16'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
